// File: rtl/xc20xx_cfg_pkg.sv
// Shared state encoding and bitstream framing constants for the XC20XX
// serial configuration loader.
package xc20xx_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE, SYNC, LENGTH, HDR_END, F_START, F_DATA, F_STOP, POST, DONE, ERR
  } cfg_state_e;

  localparam logic [3:0] SYNC_PATTERN      = 4'b0010;
  localparam int         MIN_PREAMBLE_ONES = 4;
  localparam int         PREAMBLE_SAT      = 15;
  localparam int         HDR_END_ONES      = 4;
  localparam int         STOP_ONES         = 3;
  localparam int         DEF_LEN_BITS      = 24;

endpackage

// File: rtl/xc20xx_cfg_frame_sr.sv
// Frame assembly shift register: MSB-first, new bit enters the LSB.
// o_full is high while the next shift is the last bit of the frame.
module xc20xx_cfg_frame_sr
  import xc20xx_cfg_pkg::*;
#(
  parameter int FRAME_BITS = 71
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_shift,
  input  logic                  i_clr,
  input  logic                  i_bit,
  output logic [FRAME_BITS-1:0] o_data,
  output logic                  o_full
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  logic [FRAME_BITS-1:0] r_data;
  logic [CW-1:0]         r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_shift) r_data <= {r_data[FRAME_BITS-2:0], i_bit};
      // Counter wraps on the final bit so back-to-back frames need no clear.
      if (i_clr || (i_shift && o_full)) r_cnt <= '0;
      else if (i_shift)                 r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_full = (r_cnt == CW'(FRAME_BITS - 1));

endmodule

// File: rtl/xc20xx_cfg_loader.sv
// Serial bitstream parser: preamble, sync, length, header end, framed data
// and postamble; writes each completed frame to the configuration array.
module xc20xx_cfg_loader
  import xc20xx_cfg_pkg::*;
#(
  parameter  int FRAME_BITS = 71,
  parameter  int NUM_FRAMES = 160,
  parameter  int LEN_BITS   = DEF_LEN_BITS,
  localparam int ADDR_BITS  = $clog2(NUM_FRAMES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  output logic [FRAME_BITS-1:0] o_frame_data,
  output logic [ADDR_BITS-1:0]  o_frame_addr,
  output logic                  o_frame_we,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int CNT_W = ($clog2(LEN_BITS) < 4) ? 4 : $clog2(LEN_BITS);
  localparam logic [LEN_BITS-1:0] MIN_LEN =
    LEN_BITS'(NUM_FRAMES * (FRAME_BITS + 1 + STOP_ONES));
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_FRAMES - 1);

  cfg_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [LEN_BITS-1:0]   r_len, w_len_nxt;
  logic [LEN_BITS-1:0]   r_bc, w_bc_nxt, w_bc_inc;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  r_we, w_we_nxt;
  logic                  w_shift, w_clr, w_full, w_bc_hit, w_last_frame;

  assign w_bc_inc     = r_bc + 1'b1;
  assign w_bc_hit     = (w_bc_inc == r_len);
  assign w_last_frame = (r_addr == LAST_ADDR);
  assign w_clr        = (r_state != F_DATA);

  xc20xx_cfg_frame_sr #(.FRAME_BITS(FRAME_BITS)) u_frame_sr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_shift (w_shift),
    .i_clr   (w_clr),
    .i_bit   (i_din),
    .o_data  (o_frame_data),
    .o_full  (w_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_bc    <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_bc    <= w_bc_nxt;
      r_we    <= w_we_nxt;
      // Address advances after the strobe cycle and parks on the last frame.
      if (r_we && !w_last_frame) r_addr <= r_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_bc_nxt    = r_bc;
    w_we_nxt    = 1'b0;
    w_shift     = 1'b0;
    if (i_din_valid) begin
      case (r_state)
        IDLE: begin
          if (i_din) begin
            if (r_cnt != CNT_W'(PREAMBLE_SAT)) w_cnt_nxt = r_cnt + 1'b1;
          end else begin
            w_cnt_nxt = '0;
            if (r_cnt >= CNT_W'(MIN_PREAMBLE_ONES)) w_state_nxt = SYNC;
          end
        end
        SYNC: begin
          // The leading 0 of the pattern was consumed as the sync detect.
          if (i_din != SYNC_PATTERN[2'd2 - r_cnt[1:0]]) w_state_nxt = ERR;
          else if (r_cnt == CNT_W'(2)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = LENGTH;
          end else w_cnt_nxt = r_cnt + 1'b1;
        end
        LENGTH: begin
          w_len_nxt = {r_len[LEN_BITS-2:0], i_din};
          if (r_cnt == CNT_W'(LEN_BITS - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (w_len_nxt < MIN_LEN) ? ERR : HDR_END;
          end else w_cnt_nxt = r_cnt + 1'b1;
        end
        HDR_END: begin
          if (!i_din) w_state_nxt = ERR;
          else if (r_cnt == CNT_W'(HDR_END_ONES - 1)) begin
            w_cnt_nxt   = '0;
            w_bc_nxt    = '0;
            w_state_nxt = F_START;
          end else w_cnt_nxt = r_cnt + 1'b1;
        end
        F_START: begin
          w_bc_nxt = w_bc_inc;
          if (i_din || w_bc_hit) w_state_nxt = ERR;
          else                   w_state_nxt = F_DATA;
        end
        F_DATA: begin
          w_bc_nxt = w_bc_inc;
          w_shift  = 1'b1;
          if (w_bc_hit) w_state_nxt = ERR;
          else if (w_full) begin
            w_cnt_nxt   = '0;
            w_state_nxt = F_STOP;
          end
        end
        F_STOP: begin
          w_bc_nxt = w_bc_inc;
          if (!i_din) w_state_nxt = ERR;
          else if (r_cnt == CNT_W'(STOP_ONES - 1)) begin
            w_cnt_nxt = '0;
            if (w_last_frame) begin
              w_we_nxt    = 1'b1;
              w_state_nxt = w_bc_hit ? DONE : POST;
            end else if (w_bc_hit) w_state_nxt = ERR;
            else begin
              w_we_nxt    = 1'b1;
              w_state_nxt = F_START;
            end
          end else if (w_bc_hit) w_state_nxt = ERR;
          else w_cnt_nxt = r_cnt + 1'b1;
        end
        POST: begin
          w_bc_nxt = w_bc_inc;
          if (!i_din)        w_state_nxt = ERR;
          else if (w_bc_hit) w_state_nxt = DONE;
        end
        DONE, ERR: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign o_frame_addr = r_addr;
  assign o_frame_we   = r_we;
  assign o_busy       = r_state inside {SYNC, LENGTH, HDR_END, F_START, F_DATA, F_STOP, POST};
  assign o_done       = (r_state == DONE);
  assign o_error      = (r_state == ERR);

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Directed plus randomized bitstreams checked against a bit-list parser model.
module tb_xc20xx_cfg_loader;

  localparam int FB = 8;
  localparam int NF = 2;
  localparam int LB = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic [FB-1:0] frame_data;
  logic [0:0]    frame_addr;
  logic          frame_we, busy, done, error;

  xc20xx_cfg_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF), .LEN_BITS(LB)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .o_frame_data (frame_data),
    .o_frame_addr (frame_addr),
    .o_frame_we   (frame_we),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         accepted;
  int         got_done_at, got_err_at;
  logic [8:0] got_q[$];
  bit         stream[$];
  logic [8:0] exp_q[$];
  int         exp_done_at, exp_err_at, exp_addr;
  bit         exp_busy;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_we) got_q.push_back({frame_addr, frame_data});
      if (done && got_done_at < 0) got_done_at = accepted;
      if (error && got_err_at < 0) got_err_at = accepted;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the bit list with the bitstream grammar; positions are
  // counts of accepted bits, so an event "at p" is visible after the p-th bit.
  task automatic get(inout int p, output int b);
    if (p >= stream.size()) b = -1;
    else begin
      b = int'(stream[p]);
      p++;
    end
  endtask

  task automatic fail_at(input int p);
    exp_err_at = p;
    exp_busy   = 1'b0;
  endtask

  task automatic model();
    int p = 0, ones = 0, b = 0, len = 0, hs = 0;
    logic [FB-1:0] d = '0;
    exp_q.delete();
    exp_done_at = -1; exp_err_at = -1; exp_busy = 1'b0; exp_addr = 0;
    forever begin
      get(p, b);
      if (b < 0) return;
      if (b == 1) ones = (ones < 15) ? ones + 1 : 15;
      else if (ones >= 4) break;
      else ones = 0;
    end
    exp_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      get(p, b);
      if (b < 0) return;
      if (b != ((k == 1) ? 1 : 0)) begin fail_at(p); return; end
    end
    for (int k = 0; k < LB; k++) begin
      get(p, b);
      if (b < 0) return;
      len = len * 2 + b;
    end
    if (len < NF * (FB + 4)) begin fail_at(p); return; end
    for (int k = 0; k < 4; k++) begin
      get(p, b);
      if (b < 0) return;
      if (b != 1) begin fail_at(p); return; end
    end
    hs = p;
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k < FB + 4; k++) begin
        get(p, b);
        if (b < 0) return;
        if ((k == 0 && b != 0) || (k > FB && b != 1)) begin fail_at(p); return; end
        if (k >= 1 && k <= FB) d[FB-k] = b[0];
        if (p - hs == len && !(f == NF - 1 && k == FB + 3)) begin fail_at(p); return; end
      end
      exp_q.push_back({1'(f), d});
      exp_addr = (f + 1 < NF) ? f + 1 : NF - 1;
    end
    if (p - hs == len) begin exp_done_at = p; exp_busy = 1'b0; return; end
    forever begin
      get(p, b);
      if (b < 0) return;
      if (b != 1) begin fail_at(p); return; end
      if (p - hs == len) begin exp_done_at = p; exp_busy = 1'b0; return; end
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
  endtask

  task automatic build(input int pre, input int len, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [2:0] stop1, input int post);
    stream.delete();
    repeat (pre) stream.push_back(1'b1);
    push_bits(32'h2, 4);
    push_bits(32'(len), LB);
    push_bits(32'hF, 4);
    push_bits({20'd0, 1'b0, d0, 3'b111}, 12);
    push_bits({20'd0, 1'b0, d1, stop1}, 12);
    repeat (post) stream.push_back(1'b1);
  endtask

  task automatic drive_bits(input int stall, input int nbits);
    for (int i = 0; i < nbits && i < stream.size(); i++) begin
      for (int s = 0; s < 20 && $urandom_range(99) < stall; s++) begin
        din = 1'($urandom_range(1)); din_valid = 1'b0;
        @(posedge clk); #1;
      end
      din = stream[i]; din_valid = 1'b1;
      @(posedge clk); accepted++; #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic start_run();
    got_q.delete();
    got_done_at = -1; got_err_at = -1; accepted = 0;
    model();
  endtask

  task automatic check_run(input string tag);
    chk({tag, "/we_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "/we_entry"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "/done_at"}, 32'(got_done_at), 32'(exp_done_at));
    chk({tag, "/err_at"}, 32'(got_err_at), 32'(exp_err_at));
    chk({tag, "/busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "/addr"}, 32'(frame_addr), 32'(exp_addr));
    chk({tag, "/done"}, 32'(done), 32'(exp_done_at >= 0));
    chk({tag, "/error"}, 32'(error), 32'(exp_err_at >= 0));
  endtask

  task automatic run_stream(input string tag, input int stall);
    start_run();
    drive_bits(stall, stream.size());
    repeat (6) @(posedge clk);
    #1;
    check_run(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/data"}, 32'(frame_data), 0);
    chk({tag, "/addr"}, 32'(frame_addr), 0);
    chk({tag, "/we"}, 32'(frame_we), 0);
    chk({tag, "/busy"}, 32'(busy), 0);
    chk({tag, "/done"}, 32'(done), 0);
    chk({tag, "/error"}, 32'(error), 0);
  endtask

  task automatic do_reset();
    din_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int pre, len, post, stall, idx;
    logic [7:0] d0, d1;

    // Reset state
    din_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal stream
    build(8, 28, 8'hA5, 8'h3C, 3'b111, 4);
    run_stream("nominal", 0);
    chk("nominal/we0", 32'((got_q.size() > 0) ? got_q[0] : 9'h1FF), 32'h0A5);
    chk("nominal/we1", 32'((got_q.size() > 1) ? got_q[1] : 9'h1FF), 32'h13C);
    chk("nominal/done_68", 32'(got_done_at), 68);

    // Same stream with random stalls
    do_reset();
    run_stream("stall", 50);
    chk("stall/done_68", 32'(got_done_at), 68);

    // Bad stop bits on second frame
    do_reset();
    build(8, 28, 8'hA5, 8'h3C, 3'b101, 4);
    run_stream("badstop", 0);
    chk("badstop/err_63", 32'(got_err_at), 63);
    chk("badstop/one_we", 32'(got_q.size()), 1);

    // Length below minimum
    do_reset();
    build(8, 20, 8'hA5, 8'h3C, 3'b111, 4);
    run_stream("shortlen", 0);
    chk("shortlen/err_36", 32'(got_err_at), 36);

    // Short preamble stays idle, then a proper stream configures
    do_reset();
    stream.delete();
    push_bits(32'b1110010, 7);
    run_stream("shortpre", 0);
    chk("shortpre/idle_busy", 32'(busy), 0);
    build(5, 28, 8'h5A, 8'hC3, 3'b111, 4);
    run_stream("shortpre2", 30);

    // Asynchronous reset in the middle of the second frame's data
    do_reset();
    build(8, 28, 8'hA5, 8'h3C, 3'b111, 4);
    start_run();
    drive_bits(0, 56);
    chk("midrst/pre_we_cnt", 32'(got_q.size()), 1);
    chk("midrst/pre_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(posedge clk); #1;
    chk_zero("midrst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_stream("midrst_after", 0);

    // Randomized streams, some with a single corrupted bit
    for (int it = 0; it < 24; it++) begin
      pre   = $urandom_range(18, 4);
      len   = $urandom_range(36, 24);
      post  = len - 24 + $urandom_range(3, 0) - (($urandom_range(9) == 0) ? 1 : 0);
      if (post < 0) post = 0;
      d0    = 8'($urandom);
      d1    = 8'($urandom);
      stall = $urandom_range(60, 0);
      build(pre, len, d0, d1, 3'b111, post);
      if ($urandom_range(99) < 35) begin
        idx = $urandom_range(stream.size() - 1, 0);
        stream[idx] = ~stream[idx];
      end
      do_reset();
      run_stream("random", stall);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
